// File: rtl/agc_ahb_pkg.sv
// Shared AHB-Lite encodings and the command-master FSM state type.
package agc_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    ERR2 = 3'd3,
    RSP  = 3'd4
  } state_e;

endpackage

// File: rtl/ahb_wait_watchdog.sv
// Counts data-phase wait states; expired is high once TIMEOUT-1 waits have elapsed.
module ahb_wait_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST so the counter can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/agc_ahb_cmd_master.sv
// Single-outstanding AHB-Lite master: one valid/ready command in, one word transfer,
// one response out. Handles wait states, two-cycle ERROR and a data-phase watchdog.
module agc_ahb_cmd_master
  import agc_ahb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic          hwrite,
  output logic [2:0]    hsize,
  output logic [2:0]    hburst,
  output logic [DW-1:0] hwdata,
  input  logic [DW-1:0] hrdata,
  input  logic          hready,
  input  logic          hresp
);

  // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready,
  // a response on one where rsp_valid && rsp_ready; the producer holds its payload
  // stable until that edge.

  state_e        state_q, state_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic          hwrite_q, hwrite_d;
  logic [DW-1:0] hwdata_q, hwdata_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  logic wd_clear, wd_tick, wd_expired;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^cmd_addr[1:0];

  assign wd_clear = (state_q != DATA);
  assign wd_tick  = (state_q == DATA) && !hready;

  ahb_wait_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .tick   (wd_tick),
    .expired(wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    haddr_d       = haddr_q;
    hwrite_d      = hwrite_q;
    hwdata_d      = hwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = ADDR;
          haddr_d  = {cmd_addr[AW-1:2], 2'b00};
          hwrite_d = cmd_write;
          hwdata_d = cmd_wdata;
        end
      end
      ADDR: begin
        if (hready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        // A completing cycle wins over the watchdog; hresp with hready is the
        // illegal single-cycle error and still reports an error.
        if (hready) begin
          state_d       = RSP;
          rsp_err_d     = hresp;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!hwrite_q && !hresp) ? hrdata : '0;
        end else if (hresp) begin
          state_d = ERR2;
        end else if (wd_expired) begin
          state_d       = RSP;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end
      end
      ERR2: begin
        if (hready) begin
          state_d       = RSP;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d       = IDLE;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    htrans_d    = (state_d == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      haddr_q       <= '0;
      hwrite_q      <= 1'b0;
      hwdata_q      <= '0;
      htrans_q      <= HTRANS_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      haddr_q       <= haddr_d;
      hwrite_q      <= hwrite_d;
      hwdata_q      <= hwdata_d;
      htrans_q      <= htrans_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign haddr       = haddr_q;
  assign htrans      = htrans_q;
  assign hwrite      = hwrite_q;
  assign hwdata      = hwdata_q;
  assign hsize       = HSIZE_WORD;
  assign hburst      = HBURST_SINGLE;

endmodule

// File: tb/tb_agc_ahb_cmd_master.sv
// Bench for agc_ahb_cmd_master: a behavioural AHB slave plus a latency/response
// model derived from the transfer's phase lengths.
module tb_agc_ahb_cmd_master;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  localparam int M_OK   = 0;
  localparam int M_ERR2 = 1;
  localparam int M_ILL  = 2;
  localparam int M_HANG = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  agc_ahb_cmd_master #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp)
  );

  // One complete command: drives the command, plays the slave, checks the response.
  // Called and returning at a negedge.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits, input int astall,
                         input int mode, input int hold, input logic keep_valid,
                         input string name);
    int acc, ns, sp, dp, as_left, hold_left, lat_exp, start;
    logic accepted, got, done;
    logic [31:0] exp_rdata, s_rdata, exp_addr;
    logic exp_err, exp_to, s_err, s_to;

    exp_err   = (mode != M_OK);
    exp_to    = (mode == M_HANG);
    exp_rdata = (mode == M_OK && !wr) ? rdata : 32'h0;
    exp_addr  = {addr[31:2], 2'b00};
    case (mode)
      M_ERR2:  lat_exp = 1 + (1 + astall) + (waits + 1) + 1;
      M_HANG:  lat_exp = 1 + (1 + astall) + TIMEOUT;
      default: lat_exp = 1 + (1 + astall) + (waits + 1);
    endcase

    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    accepted = 1'b0; got = 1'b0; done = 1'b0;
    ns = 0; sp = 0; dp = 0; acc = 0;
    as_left = astall; hold_left = hold; start = cyc;
    s_rdata = '0; s_err = 1'b0; s_to = 1'b0;

    while (1) begin
      if (done) begin
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s release: rsp_valid=%b cmd_ready=%b required 0/1", name, rsp_valid, cmd_ready);
        end
        checks++;
        if (ns != 1 + astall) begin
          failures++;
          $display("FAIL %s nonseq_cycles: got %0d required %0d", name, ns, 1 + astall);
        end
        rsp_ready = 1'b0;
        break;
      end

      if (!accepted && cmd_valid && cmd_ready) begin
        accepted = 1'b1;
        acc = cyc;
      end else if (accepted) begin
        if (!keep_valid) cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s cmd_ready_busy: got %b required 0", name, cmd_ready);
        end
      end

      if (htrans == 2'b10) begin
        ns++;
        checks++;
        if (haddr !== exp_addr || hwrite !== wr) begin
          failures++;
          $display("FAIL %s addr_phase: haddr=%h hwrite=%b required %h/%b", name, haddr, hwrite, exp_addr, wr);
        end
      end

      // Slave model
      hrdata = $urandom;
      hresp  = 1'b0;
      hready = 1'b1;
      case (sp)
        0: begin
          if (htrans == 2'b10) begin
            if (as_left > 0) begin
              hready = 1'b0;
              as_left--;
            end else begin
              sp = 1;
              dp = 0;
            end
          end
        end
        1: begin
          if (dp == 0) begin
            checks++;
            if (htrans !== 2'b00 || (wr && hwdata !== wdata)) begin
              failures++;
              $display("FAIL %s data_phase: htrans=%b hwdata=%h required 00/%h", name, htrans, hwdata, wdata);
            end
          end
          if (mode == M_HANG || dp < waits) begin
            hready = 1'b0;
          end else if (mode == M_OK) begin
            hrdata = rdata;
            sp = 0;
          end else if (mode == M_ERR2) begin
            hready = 1'b0;
            hresp  = 1'b1;
            sp = 2;
          end else begin
            hresp = 1'b1;
            sp = 0;
          end
          dp++;
        end
        default: begin
          checks++;
          if (htrans !== 2'b00) begin
            failures++;
            $display("FAIL %s err2_htrans: got %b required 00", name, htrans);
          end
          hresp = 1'b1;
          sp = 0;
        end
      endcase

      if (rsp_valid) begin
        if (!got) begin
          got = 1'b1;
          sp = 0;
          checks++;
          if (!accepted || cyc - acc != lat_exp) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", name, cyc - acc, lat_exp);
          end
          checks++;
          if (rsp_rdata !== exp_rdata || rsp_err !== exp_err || rsp_timeout !== exp_to) begin
            failures++;
            $display("FAIL %s response: rdata=%h err=%b to=%b required %h/%b/%b",
                     name, rsp_rdata, rsp_err, rsp_timeout, exp_rdata, exp_err, exp_to);
          end
          s_rdata = rsp_rdata; s_err = rsp_err; s_to = rsp_timeout;
        end else begin
          checks++;
          if (rsp_rdata !== s_rdata || rsp_err !== s_err || rsp_timeout !== s_to) begin
            failures++;
            $display("FAIL %s rsp_hold: rdata=%h err=%b to=%b required %h/%b/%b",
                     name, rsp_rdata, rsp_err, rsp_timeout, s_rdata, s_err, s_to);
          end
        end
        if (hold_left > 0) begin
          hold_left--;
          rsp_ready = 1'b0;
        end else begin
          rsp_ready = 1'b1;
          done = 1'b1;
        end
      end

      if (cyc - start > 300) begin
        checks++;
        failures++;
        $display("FAIL %s cycle_budget: no response within %0d cycles", name, 300);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h5;
    rsp_ready = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (htrans !== 2'b00 || haddr !== 32'h0 || hwrite !== 1'b0 || hwdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: htrans=%b haddr=%h hwrite=%b hwdata=%h required 00/0/0/0", htrans, haddr, hwrite, hwdata);
    end
    checks++;
    if (hsize !== 3'b010 || hburst !== 3'b000) begin
      failures++;
      $display("FAIL reset_consts: hsize=%b hburst=%b required 010/000", hsize, hburst);
    end
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_handshake: cmd_ready=%b rsp_valid=%b err=%b to=%b rdata=%h required all 0",
               cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || htrans !== 2'b00) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b htrans=%b required 1/00", cmd_ready, htrans);
    end
  endtask

  task automatic test_zero_wait_write();
    run_cmd(1'b1, 32'h0000_0004, 32'h0000_0064, 32'h0, 0, 0, M_OK, 0, 1'b0, "zero_wait_write");
  endtask

  task automatic test_wait_read();
    run_cmd(1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 3, 0, M_OK, 0, 1'b0, "wait_read");
  endtask

  task automatic test_error();
    run_cmd(1'b0, 32'h0000_000C, 32'h0, $urandom, 0, 0, M_ERR2, 0, 1'b0, "err2_read");
    run_cmd(1'b1, $urandom, $urandom, $urandom, 2, 1, M_ERR2, 1, 1'b0, "err2_write");
    run_cmd(1'b0, $urandom, 32'h0, $urandom, 1, 0, M_ILL, 0, 1'b0, "single_cycle_err");
  endtask

  task automatic test_timeout();
    run_cmd(1'b0, 32'h0000_0010, 32'h0, $urandom, 0, 0, M_HANG, 0, 1'b0, "timeout_read");
    run_cmd(1'b1, $urandom, $urandom, 32'h0, 0, 2, M_HANG, 0, 1'b0, "timeout_astall");
  endtask

  task automatic test_backpressure();
    logic [31:0] a, d;
    a = $urandom; d = $urandom;
    run_cmd(1'b1, a, d, 32'h0, 1, 0, M_OK, 10, 1'b1, "backpressure");
    run_cmd(1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 0, 0, M_OK, 0, 1'b0, "after_release");
  endtask

  task automatic test_reset_mid();
    cmd_write = 1'b1; cmd_addr = 32'h0000_0040; cmd_wdata = 32'hCAFE_0001; cmd_valid = 1'b1;
    hready = 1'b1; hresp = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (htrans !== 2'b10) begin
      failures++;
      $display("FAIL rst_mid_addr: htrans=%b required 10", htrans);
    end
    @(negedge clk);
    checks++;
    if (htrans !== 2'b00 || hwdata !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL rst_mid_data: htrans=%b hwdata=%h required 00/cafe0001", htrans, hwdata);
    end
    hready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (htrans !== 2'b00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_abort: htrans=%b rsp_valid=%b cmd_ready=%b required 00/0/0", htrans, rsp_valid, cmd_ready);
    end
    reset = 1'b0;
    hready = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_release: cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
    end
    run_cmd(1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 1, 0, M_OK, 0, 1'b0, "read_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) mode = M_HANG;
      run_cmd($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom,
              $urandom_range(0, 4), $urandom_range(0, 2), mode, $urandom_range(0, 3),
              1'b0, "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_error();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
